// File: rtl/nonce_result_checker.sv
// Scans NUM_NONCES H0 result words against a difficulty target, tracks the lowest
// winning nonce and the minimum hash, then writes a 3-word summary record.
// Optional: NONCE_CHECK_EARLY_EXIT_EN stops the scan after the first winner.
module nonce_result_checker #(
    parameter int unsigned NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        found,
    output logic [7:0]  found_nonce,
    output logic [31:0] min_hash,
    output logic [7:0]  min_nonce
);

    localparam int unsigned CNT_W  = $clog2(NUM_NONCES + 1);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 8;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   rcnt, rcnt_nx;
    logic [1:0]         wcnt, wcnt_nx;
    logic [ADDR_W-1:0]  hash_q, hash_nx, res_q, res_nx;
    logic [DATA_W-1:0]  target_q, target_nx;
    logic               done_nx, we_nx, found_nx;
    logic [ADDR_W-1:0]  addr_nx;
    logic [DATA_W-1:0]  wdata_nx, min_hash_nx;
    logic [IDX_W-1:0]   found_nonce_nx, min_nonce_nx, nonce;
    logic               consume, to_write;
`ifdef NONCE_CHECK_EARLY_EXIT_EN
    logic               exit_q, exit_nx;
`endif

    assign mem_clk = clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            rcnt           <= '0;
            wcnt           <= '0;
            hash_q         <= '0;
            res_q          <= '0;
            target_q       <= '0;
            done           <= 1'b1;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            found          <= 1'b0;
            found_nonce    <= '0;
            min_hash       <= '1;
            min_nonce      <= '0;
`ifdef NONCE_CHECK_EARLY_EXIT_EN
            exit_q         <= 1'b0;
`endif
        end else begin
            state          <= state_nx;
            rcnt           <= rcnt_nx;
            wcnt           <= wcnt_nx;
            hash_q         <= hash_nx;
            res_q          <= res_nx;
            target_q       <= target_nx;
            done           <= done_nx;
            mem_we         <= we_nx;
            mem_addr       <= addr_nx;
            mem_write_data <= wdata_nx;
            found          <= found_nx;
            found_nonce    <= found_nonce_nx;
            min_hash       <= min_hash_nx;
            min_nonce      <= min_nonce_nx;
`ifdef NONCE_CHECK_EARLY_EXIT_EN
            exit_q         <= exit_nx;
`endif
        end
    end

    // Next-state and datapath: read data lags its address by one cycle, so cycle r scores nonce r-1
    always_comb begin
        state_nx       = state;
        rcnt_nx        = rcnt;
        wcnt_nx        = wcnt;
        hash_nx        = hash_q;
        res_nx         = res_q;
        target_nx      = target_q;
        done_nx        = done;
        we_nx          = 1'b0;
        addr_nx        = mem_addr;
        wdata_nx       = mem_write_data;
        found_nx       = found;
        found_nonce_nx = found_nonce;
        min_hash_nx    = min_hash;
        min_nonce_nx   = min_nonce;
        nonce          = IDX_W'(rcnt - CNT_W'(1));
        consume        = 1'b0;
        to_write       = 1'b0;
`ifdef NONCE_CHECK_EARLY_EXIT_EN
        exit_nx        = exit_q;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    hash_nx        = hash_addr;
                    res_nx         = result_addr;
                    target_nx      = target;
                    found_nx       = 1'b0;
                    found_nonce_nx = '0;
                    min_hash_nx    = '1;
                    min_nonce_nx   = '0;
                    rcnt_nx        = '0;
                    addr_nx        = hash_addr;
                    done_nx        = 1'b0;
                    state_nx       = READ;
`ifdef NONCE_CHECK_EARLY_EXIT_EN
                    exit_nx        = 1'b0;
`endif
                end
            end

            READ: begin
                consume = (rcnt != '0);
`ifdef NONCE_CHECK_EARLY_EXIT_EN
                if (exit_q) begin
                    consume  = 1'b0;
                    to_write = 1'b1;
                end
`endif
                if (consume) begin
                    if (mem_read_data < target_q && !found) begin
                        found_nx       = 1'b1;
                        found_nonce_nx = nonce;
`ifdef NONCE_CHECK_EARLY_EXIT_EN
                        exit_nx        = 1'b1;
`endif
                    end
                    // Nonce 0 always seeds the minimum, even when it is all-ones
                    if (rcnt == CNT_W'(1) || mem_read_data < min_hash) begin
                        min_hash_nx  = mem_read_data;
                        min_nonce_nx = nonce;
                    end
                end
                rcnt_nx = rcnt + CNT_W'(1);
                addr_nx = hash_q + ADDR_W'(rcnt) + ADDR_W'(1);
                if (rcnt == CNT_W'(NUM_NONCES)) begin
                    to_write = 1'b1;
                end
                if (to_write) begin
                    state_nx = WRITE;
                    wcnt_nx  = '0;
                    we_nx    = 1'b1;
                    addr_nx  = res_q;
                    wdata_nx = {found_nx, 23'b0, found_nonce_nx};
                end
            end

            WRITE: begin
                case (wcnt)
                    2'd0: begin
                        we_nx    = 1'b1;
                        addr_nx  = res_q + ADDR_W'(1);
                        wdata_nx = min_hash;
                        wcnt_nx  = 2'd1;
                    end
                    2'd1: begin
                        we_nx    = 1'b1;
                        addr_nx  = res_q + ADDR_W'(2);
                        wdata_nx = {24'b0, min_nonce};
                        wcnt_nx  = 2'd2;
                    end
                    default: begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                endcase
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule
